series_job_dispatcher: RTL and testbench

- Host-side initiator for the iterative series-evaluation engine. It is the other end of that engine's start/done handshake.
- Accepts operand jobs on a valid/ready input and drives the engine's start/operand lines with the required start-hold pulse.
- Waits for the engine's done pulse, with a timeout watchdog, then presents the captured result on a valid/ready output.
- Keeps job and error statistics. Sits between the top-level command interface and the series engine.

---
 rtl/series_job_dispatcher.sv | 142 ++++++++++++++
 tb/tb_series_job_dispatcher.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/series_job_dispatcher.sv
// Host-side initiator for the series-evaluation engine: issues one job at a time,
// holds start for a fixed number of cycles, waits for done under a watchdog, and returns the result.
module series_job_dispatcher #(
   parameter int WIDTH        = 16,
   parameter int START_CYCLES = 2,
   parameter int TIMEOUT      = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_x_i,
   output logic             eng_start_o,
   output logic [WIDTH-1:0] eng_x_o,
   input  logic             eng_done_i,
   input  logic [WIDTH-1:0] eng_result_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_result_o,
   output logic             out_err_o,
   output logic             busy_o,
   output logic [15:0]      job_count_o,
   output logic [7:0]       err_count_o
);

   // state   | meaning
   // S_IDLE  | ready for a job, in_ready high
   // S_START | eng_start held high, counting START_CYCLES
   // S_WAIT  | waiting for eng_done, watchdog counting down
   // S_HOLD  | result presented, waiting for out_ready
   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_HOLD} state_t;

   localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] START_LOAD   = CW'(START_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             eng_start_q, eng_start_d;
   logic [WIDTH-1:0] eng_x_q, eng_x_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_result_q, out_result_d;
   logic             out_err_q, out_err_d;
   logic [15:0]      job_count_q, job_count_d;
   logic [7:0]       err_count_q, err_count_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         eng_start_q  <= 1'b0;
         eng_x_q      <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_err_q    <= 1'b0;
         job_count_q  <= '0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         eng_start_q  <= eng_start_d;
         eng_x_q      <= eng_x_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_err_q    <= out_err_d;
         job_count_q  <= job_count_d;
         err_count_q  <= err_count_d;
      end
   end

   // One down-counter serves both the start-hold and the watchdog; each phase reloads it.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      eng_start_d  = eng_start_q;
      eng_x_d      = eng_x_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_err_d    = out_err_q;
      job_count_d  = job_count_q;
      err_count_d  = err_count_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               eng_x_d     = in_x_i;
               eng_start_d = 1'b1;
               cnt_d       = START_LOAD;
               state_d     = S_START;
            end
         end
         S_START: begin
            if (cnt_q == '0) begin
               eng_start_d = 1'b0;
               cnt_d       = TIMEOUT_LOAD;
               state_d     = S_WAIT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_WAIT: begin
            // done takes priority over a watchdog expiry in the same cycle
            if (eng_done_i) begin
               out_result_d = eng_result_i;
               out_err_d    = 1'b0;
               out_valid_d  = 1'b1;
               job_count_d  = job_count_q + 16'd1;
               state_d      = S_HOLD;
            end else if (cnt_q == '0) begin
               out_result_d = '0;
               out_err_d    = 1'b1;
               out_valid_d  = 1'b1;
               job_count_d  = job_count_q + 16'd1;
               if (err_count_q != 8'hFF) begin
                  err_count_d = err_count_q + 8'd1;
               end
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_HOLD: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready_o   = (state_q == S_IDLE) & ~rst;
   assign busy_o       = (state_q != S_IDLE);
   assign eng_start_o  = eng_start_q;
   assign eng_x_o      = eng_x_q;
   assign out_valid_o  = out_valid_q;
   assign out_result_o = out_result_q;
   assign out_err_o    = out_err_q;
   assign job_count_o  = job_count_q;
   assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_series_job_dispatcher.sv
// Bench for series_job_dispatcher: directed jobs, expected results queued at issue time
// and checked by a monitor on each output handshake.
module tb_series_job_dispatcher;

   localparam int SC = 2;

   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [15:0] in_x;
   logic        eng_start;
   logic [15:0] eng_x;
   logic        eng_done;
   logic [15:0] eng_result;
   logic        out_valid, out_ready;
   logic [15:0] out_result;
   logic        out_err, busy;
   logic [15:0] job_count;
   logic [7:0]  err_count;

   typedef struct packed {
      logic [15:0] res;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_jobs = 16'd0;
   logic [7:0]  exp_errs = 8'd0;

   series_job_dispatcher #(.WIDTH(16), .START_CYCLES(SC), .TIMEOUT(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_x_i       (in_x),
      .eng_start_o  (eng_start),
      .eng_x_o      (eng_x),
      .eng_done_i   (eng_done),
      .eng_result_i (eng_result),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_result_o (out_result),
      .out_err_o    (out_err),
      .busy_o       (busy),
      .job_count_o  (job_count),
      .err_count_o  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got result %0h err %0b with nothing expected", out_result, out_err);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_result", {16'd0, out_result}, {16'd0, e.res});
            chk("sb_err", {31'd0, out_err}, {31'd0, e.err});
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Cycle 1 is the first cycle after the accept edge; done_cyc is the cycle eng_done is driven in.
   task automatic run_job(input logic [15:0] x, input int done_cyc, input logic [15:0] res,
                          input int spur_cyc, input logic [15:0] exp_res, input logic exp_err,
                          input int exp_out_cyc, input int ready_delay);
      int c;
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_x     = x;
      sb.push_back(exp_t'{res: exp_res, err: exp_err});
      step();
      in_valid = 1'b0;
      in_x     = 16'hA5A5;
      c        = 1;
      chk("eng_start_rise", {31'd0, eng_start}, 32'd1);
      chk("eng_x_accept", {16'd0, eng_x}, {16'd0, x});
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      while (!out_valid && c < 200) begin
         eng_done   = (c == done_cyc) || (c == spur_cyc);
         eng_result = (c == done_cyc) ? res : 16'hDEAD;
         step();
         c++;
         eng_done = 1'b0;
         if (c == SC) chk("eng_start_hold", {31'd0, eng_start}, 32'd1);
         if (c == SC + 1) chk("eng_start_fall", {31'd0, eng_start}, 32'd0);
      end
      chk("out_cycle", c, exp_out_cyc);
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("eng_x_held", {16'd0, eng_x}, {16'd0, x});
      exp_jobs = exp_jobs + 16'd1;
      if (exp_err && exp_errs != 8'hFF) exp_errs = exp_errs + 8'd1;
      chk("job_count", {16'd0, job_count}, {16'd0, exp_jobs});
      chk("err_count", {24'd0, err_count}, {24'd0, exp_errs});
      for (int i = 0; i < ready_delay; i++) begin
         in_valid   = 1'b1;
         in_x       = 16'h1234;
         eng_done   = (i == 0);
         eng_result = 16'hFFFF;
         step();
         eng_done = 1'b0;
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_result", {16'd0, out_result}, {16'd0, exp_res});
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_busy", {31'd0, busy}, 32'd1);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("exit_valid", {31'd0, out_valid}, 32'd0);
      chk("exit_busy", {31'd0, busy}, 32'd0);
      chk("exit_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_x       = 16'd0;
      eng_done   = 1'b0;
      eng_result = 16'd0;
      out_ready  = 1'b0;
      step();
      step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_eng_start", {31'd0, eng_start}, 32'd0);
      chk("rst_job_count", {16'd0, job_count}, 32'd0);
      rst = 1'b0;
      step();

      // basic: done in cycle 10, result visible in cycle 11
      run_job(16'h0100, 10, 16'h00C9, -1, 16'h00C9, 1'b0, 11, 0);
      // backpressure for 5 cycles with a pending job and a stray done in HOLD
      run_job(16'h0200, 5, 16'h0333, -1, 16'h0333, 1'b0, 6, 5);
      // timeout: 64 WAIT cycles are cycles 3..66
      run_job(16'h0300, -1, 16'h0000, -1, 16'h0000, 1'b1, 67, 0);
      run_job(16'h0400, 3, 16'h4444, -1, 16'h4444, 1'b0, 4, 0);
      // done on the 64th WAIT cycle wins over the watchdog
      run_job(16'h0500, 66, 16'hBEEF, -1, 16'hBEEF, 1'b0, 67, 0);
      // spurious done in START is ignored
      run_job(16'h0600, 12, 16'h1357, 1, 16'h1357, 1'b0, 13, 0);
      run_job(16'h0700, 9, 16'h2468, 2, 16'h2468, 1'b0, 10, 0);

      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      chk("idle_done_busy", {31'd0, busy}, 32'd0);
      chk("idle_done_valid", {31'd0, out_valid}, 32'd0);

      force dut.job_count_q = 16'hFFFF;
      #1;
      release dut.job_count_q;
      exp_jobs = 16'hFFFF;
      run_job(16'h0800, 4, 16'h0008, -1, 16'h0008, 1'b0, 5, 0);
      chk("job_wrap", {16'd0, job_count}, 32'd0);

      // reset in cycle 5 of a job
      in_valid = 1'b1;
      in_x     = 16'h4242;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_eng_start", {31'd0, eng_start}, 32'd0);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_job_count", {16'd0, job_count}, 32'd0);
      chk("mid_rst_err_count", {24'd0, err_count}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      exp_jobs = 16'd0;
      exp_errs = 8'd0;
      step();
      rst = 1'b0;
      step();
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      run_job(16'h7FFF, 8, 16'h0BEE, -1, 16'h0BEE, 1'b0, 9, 0);

      // 256 timeouts: err_count reaches and holds 0xFF
      for (int j = 0; j < 256; j++) begin
         run_job(16'h0900, -1, 16'h0000, -1, 16'h0000, 1'b1, 67, 0);
      end
      chk("err_saturate", {24'd0, err_count}, 32'h0000_00FF);
      run_job(16'h0A00, 6, 16'h5A5A, -1, 16'h5A5A, 1'b0, 7, 0);
      chk("err_hold_after_ok", {24'd0, err_count}, 32'h0000_00FF);

      step();
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
